cyt_bpss_rd_arbiter: RTL and testbench

- Shares the single Coyote descriptor-bypass read channel (command out, completion in) among N_REQ internal requesters, e.g. ACCL DMA movers and host/card stream engines.
- Round-robin grants requesters onto the command channel and records each grant's requester ID in an in-order tag FIFO.
- Routes each returning bypass completion back to the requester at the FIFO head. The downstream channel completes in order.
- Caps outstanding reads at MAX_OUT.

---
 rtl/cyt_bpss_rd_arbiter.sv | 128 ++++++++++++
 tb/tb_cyt_bpss_rd_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cyt_bpss_rd_arbiter.sv
// Round-robin arbiter sharing one descriptor-bypass read channel among
// N_REQ requesters. Grants are tagged in an in-order FIFO so returning
// completions are steered back to the requester that issued the command.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_cmd_data/valid/ready   per-requester command inputs (slice i = requester i)
//   m_cmd_data/valid/ready   registered command output to the bypass channel
//   s_sts_data/valid/ready   completion input from the bypass read-done channel
//   m_sts_data/valid/ready   completion broadcast, one-hot valid per requester
//   outstanding              commands granted and not yet completed
//   err_orphan               sticky flag: completion seen with nothing outstanding
module cyt_bpss_rd_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned CMD_W   = 96,
   parameter int unsigned STS_W   = 32,
   parameter int unsigned MAX_OUT = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [N_REQ*CMD_W-1:0]   s_cmd_data,
   input  logic [N_REQ-1:0]         s_cmd_valid,
   output logic [N_REQ-1:0]         s_cmd_ready,
   output logic [CMD_W-1:0]         m_cmd_data,
   output logic                     m_cmd_valid,
   input  logic                     m_cmd_ready,
   input  logic [STS_W-1:0]         s_sts_data,
   input  logic                     s_sts_valid,
   output logic                     s_sts_ready,
   output logic [STS_W-1:0]         m_sts_data,
   output logic [N_REQ-1:0]         m_sts_valid,
   input  logic [N_REQ-1:0]         m_sts_ready,
   output logic [$clog2(MAX_OUT):0] outstanding,
   output logic                     err_orphan
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned PTR_W = $clog2(MAX_OUT);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  winner;
   logic             found;
   logic             cmd_free;
   logic             not_full;
   logic             grant;
   logic             empty;
   logic             pop;
   logic [ID_W-1:0]  head;
   logic [ID_W-1:0]  tag_mem [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Completion routing: the head tag owns the returning completion.
   assign empty       = (outstanding == '0);
   assign head        = tag_mem[rd_ptr];
   assign m_sts_data  = s_sts_data;
   assign s_sts_ready = empty ? 1'b1 : m_sts_ready[head];
   assign pop         = s_sts_valid && !empty && m_sts_ready[head];

   always_comb begin
      m_sts_valid = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         m_sts_valid[i] = s_sts_valid && !empty && (head == ID_W'(i));
      end
   end

   // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      int unsigned idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % N_REQ;
         if (!found && s_cmd_valid[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   // A same-cycle completion pop frees a tag slot for this cycle's grant.
   // Grant is held off while reset is asserted so ready reads 0 in reset.
   assign cmd_free = !m_cmd_valid || m_cmd_ready;
   assign not_full = (outstanding < CNT_W'(MAX_OUT)) || pop;
   assign grant    = aresetn && cmd_free && not_full && found;

   always_comb begin
      s_cmd_ready = '0;
      if (grant) s_cmd_ready[winner] = 1'b1;
   end

   // Command register, RR pointer, tag pointers, count and orphan flag.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_cmd_data  <= '0;
         m_cmd_valid <= 1'b0;
         rr_ptr      <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         err_orphan  <= 1'b0;
      end else begin
         if (grant) begin
            m_cmd_data  <= s_cmd_data[32'(winner)*CMD_W +: CMD_W];
            m_cmd_valid <= 1'b1;
            rr_ptr      <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end else if (m_cmd_ready) begin
            m_cmd_valid <= 1'b0;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({grant, pop})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (s_sts_valid && empty) err_orphan <= 1'b1;
      end
   end

   // Tag storage needs no reset: entries are only read below the count.
   always_ff @(posedge aclk) begin
      if (grant) tag_mem[wr_ptr] <= winner;
   end

endmodule

// File: tb/tb_cyt_bpss_rd_arbiter.sv
// Self-checking bench for cyt_bpss_rd_arbiter: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_cyt_bpss_rd_arbiter;

   localparam int N_REQ   = 4;
   localparam int CMD_W   = 96;
   localparam int STS_W   = 32;
   localparam int MAX_OUT = 16;

   logic                     aclk = 1'b0;
   logic                     aresetn = 1'b0;
   logic [N_REQ*CMD_W-1:0]   s_cmd_data = '0;
   logic [N_REQ-1:0]         s_cmd_valid = '0;
   logic [N_REQ-1:0]         s_cmd_ready;
   logic [CMD_W-1:0]         m_cmd_data;
   logic                     m_cmd_valid;
   logic                     m_cmd_ready = 1'b0;
   logic [STS_W-1:0]         s_sts_data = '0;
   logic                     s_sts_valid = 1'b0;
   logic                     s_sts_ready;
   logic [STS_W-1:0]         m_sts_data;
   logic [N_REQ-1:0]         m_sts_valid;
   logic [N_REQ-1:0]         m_sts_ready = '0;
   logic [$clog2(MAX_OUT):0] outstanding;
   logic                     err_orphan;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit               mdl_vld;
   logic [CMD_W-1:0] mdl_data;
   int               mdl_rr;
   int               mdl_tags[$];
   bit               mdl_err;

   always #5 aclk = ~aclk;

   cyt_bpss_rd_arbiter #(
      .N_REQ(N_REQ), .CMD_W(CMD_W), .STS_W(STS_W), .MAX_OUT(MAX_OUT)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_cmd_data(s_cmd_data), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .m_cmd_data(m_cmd_data), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
      .s_sts_data(s_sts_data), .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready),
      .m_sts_data(m_sts_data), .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready),
      .outstanding(outstanding), .err_orphan(err_orphan)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mdl_vld  = 0;
      mdl_data = '0;
      mdl_rr   = 0;
      mdl_tags.delete();
      mdl_err  = 0;
   endtask

   task automatic rand_cmd_data();
      for (int i = 0; i < N_REQ; i++)
         s_cmd_data[i*CMD_W +: CMD_W] = {$urandom, $urandom, $urandom};
   endtask

   // Called at a falling edge with inputs already applied; checks, then
   // advances the model across the next rising edge.
   task automatic step();
      logic [N_REQ-1:0] exp_rdy, exp_sv;
      logic [CMD_W-1:0] win_data;
      bit               exp_ssr, free, pop, room, grant, orphan;
      int               win, sz;
      #1;
      sz      = mdl_tags.size();
      free    = !mdl_vld || m_cmd_ready;
      pop     = s_sts_valid && sz > 0 && m_sts_ready[mdl_tags[0]];
      orphan  = s_sts_valid && sz == 0;
      room    = (sz < MAX_OUT) || pop;
      win     = -1;
      for (int k = 0; k < N_REQ; k++)
         if (win < 0 && s_cmd_valid[(mdl_rr + k) % N_REQ]) win = (mdl_rr + k) % N_REQ;
      grant    = free && room && (win >= 0);
      exp_rdy  = grant ? (N_REQ'(1) << win) : '0;
      exp_ssr  = (sz == 0) ? 1'b1 : m_sts_ready[mdl_tags[0]];
      exp_sv   = (s_sts_valid && sz > 0) ? (N_REQ'(1) << mdl_tags[0]) : '0;
      win_data = grant ? s_cmd_data[win*CMD_W +: CMD_W] : '0;

      check("m_cmd_valid", 128'(m_cmd_valid), 128'(mdl_vld));
      check("m_cmd_data",  128'(m_cmd_data),  128'(mdl_data));
      check("outstanding", 128'(outstanding), 128'(sz));
      check("err_orphan",  128'(err_orphan),  128'(mdl_err));
      check("s_cmd_ready", 128'(s_cmd_ready), 128'(exp_rdy));
      check("s_sts_ready", 128'(s_sts_ready), 128'(exp_ssr));
      check("m_sts_valid", 128'(m_sts_valid), 128'(exp_sv));
      if (s_sts_valid) check("m_sts_data", 128'(m_sts_data), 128'(s_sts_data));

      @(posedge aclk);
      if (pop) void'(mdl_tags.pop_front());
      if (grant) begin
         mdl_tags.push_back(win);
         mdl_data = win_data;
         mdl_vld  = 1;
         mdl_rr   = (win + 1) % N_REQ;
      end else if (m_cmd_ready) begin
         mdl_vld = 0;
      end
      if (orphan) mdl_err = 1;
      @(negedge aclk);
   endtask

   initial begin
      int guard;
      model_reset();

      // Reset state, with requesters valid to show ready is held low
      s_cmd_valid = '1;
      #1;
      check("rst m_cmd_valid", 128'(m_cmd_valid), 128'(0));
      check("rst m_cmd_data",  128'(m_cmd_data),  128'(0));
      check("rst s_cmd_ready", 128'(s_cmd_ready), 128'(0));
      check("rst outstanding", 128'(outstanding), 128'(0));
      check("rst err_orphan",  128'(err_orphan),  128'(0));
      s_cmd_valid = '0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;

      // Single requester 2, command 0xA5, completion 0x11
      m_cmd_ready = 1'b1;
      m_sts_ready = '1;
      s_cmd_data  = '0;
      s_cmd_data[2*CMD_W +: CMD_W] = CMD_W'('hA5);
      s_cmd_valid = 4'b0100;
      step();
      s_cmd_valid = '0;
      #1;
      check("single m_cmd_data",  128'(m_cmd_data),  128'('hA5));
      check("single outstanding", 128'(outstanding), 128'(1));
      step();
      s_sts_data  = 32'h11;
      s_sts_valid = 1'b1;
      #1;
      check("single m_sts_valid", 128'(m_sts_valid), 128'(4'b0100));
      step();
      s_sts_valid = 1'b0;
      step();

      // All requesters valid for 8 cycles, then 8 in-order completions
      model_reset();
      aresetn = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         rand_cmd_data();
         s_cmd_valid = '1;
         #1;
         check("rr order", 128'(s_cmd_ready), 128'(N_REQ'(1) << (c % N_REQ)));
         step();
      end
      s_cmd_valid = '0;
      for (int c = 0; c < 8; c++) begin
         s_sts_data  = STS_W'(c);
         s_sts_valid = 1'b1;
         #1;
         check("cpl route", 128'(m_sts_valid), 128'(N_REQ'(1) << (c % N_REQ)));
         step();
      end
      s_sts_valid = 1'b0;

      // Back-pressure on the command channel for 5 cycles
      rand_cmd_data();
      s_cmd_valid = '1;
      step();
      m_cmd_ready = 1'b0;
      repeat (5) step();
      m_cmd_ready = 1'b1;
      repeat (2) step();

      // Fill to MAX_OUT with no completions, then pop-and-grant together
      for (int c = 0; c < MAX_OUT + 4; c++) begin
         rand_cmd_data();
         step();
      end
      #1;
      check("full outstanding", 128'(outstanding), 128'(MAX_OUT));
      check("full s_cmd_ready", 128'(s_cmd_ready), 128'(0));
      s_sts_valid = 1'b1;
      s_sts_data  = 32'hCAFE;
      step();
      #1;
      check("pop+grant outstanding", 128'(outstanding), 128'(MAX_OUT));

      // Drain, then an orphan completion
      s_cmd_valid = '0;
      guard = 0;
      while (mdl_tags.size() > 0 && guard < 4 * MAX_OUT) begin
         s_sts_data = $urandom;
         step();
         guard++;
      end
      check("drain bound", 128'(mdl_tags.size()), 128'(0));
      s_sts_data = 32'hDEAD;
      step();
      s_sts_valid = 1'b0;
      step();
      #1;
      check("orphan sticky",      128'(err_orphan),  128'(1));
      check("orphan outstanding", 128'(outstanding), 128'(0));
      step();

      // Randomized traffic in phases of differing completion pressure
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < 400; c++) begin
            rand_cmd_data();
            s_cmd_valid = N_REQ'($urandom);
            m_cmd_ready = ($urandom_range(0, 3) != 0);
            s_sts_valid = ($urandom_range(0, 9) < (ph * 2));
            s_sts_data  = $urandom;
            m_sts_ready = N_REQ'($urandom) | N_REQ'($urandom);
            step();
         end
      end

      // Async reset mid-stream with 5 outstanding and a pending command
      model_reset();
      aresetn = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      s_sts_valid = 1'b0;
      m_cmd_ready = 1'b1;
      s_cmd_valid = '1;
      repeat (5) begin
         rand_cmd_data();
         step();
      end
      #2;
      check("pre-rst outstanding", 128'(outstanding), 128'(5));
      aresetn = 1'b0;
      #1;
      check("async m_cmd_valid", 128'(m_cmd_valid), 128'(0));
      check("async m_cmd_data",  128'(m_cmd_data),  128'(0));
      check("async outstanding", 128'(outstanding), 128'(0));
      check("async s_cmd_ready", 128'(s_cmd_ready), 128'(0));
      model_reset();
      @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      s_cmd_valid = '1;
      #1;
      check("post-rst first grant", 128'(s_cmd_ready), 128'(1));
      step();
      s_cmd_valid = '0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
